// File: rtl/regfile.sv
// Architectural register file: general registers plus fp/sp with write bypass,
// pending-write busy bits, sp adjust with write-over-adjust priority and a sticky bad-index flag.

module regfile_slot #(
  parameter int               XLEN    = 64,
  parameter logic [5:0]       IDX     = 6'h00,
  parameter logic [XLEN-1:0]  RST_VAL = '0,
  parameter bit               IS_SP   = 1'b0
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            wr_en_i,
  input  logic [5:0]      wr_sel_i,
  input  logic [XLEN-1:0] wr_val_i,
  input  logic            sp_adj_go_i,
  input  logic            sp_adj_dec_i,
  input  logic [XLEN-1:0] sp_adj_delta_i,
  input  logic            busy_set_en_i,
  input  logic [5:0]      busy_set_sel_i,
  input  logic [5:0]      rs1_sel_i,
  input  logic [5:0]      rs2_sel_i,
  output logic [XLEN-1:0] rs1_term_o,
  output logic [XLEN-1:0] rs2_term_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o
);
  logic [XLEN-1:0] val_q, val_d, rd_val;
  logic            busy_q, busy_d;
  logic            wr_hit, set_hit, rd1_hit, rd2_hit;

  assign wr_hit  = !reset_i && wr_en_i && (wr_sel_i == IDX);
  assign set_hit = busy_set_en_i && (busy_set_sel_i == IDX);
  assign rd1_hit = (rs1_sel_i == IDX);
  assign rd2_hit = (rs2_sel_i == IDX);

  // Bypass mirrors the write that will land on this edge; the sp adjust is not bypassed.
  assign rd_val     = wr_hit ? wr_val_i : val_q;
  assign rs1_term_o = rd1_hit ? rd_val : '0;
  assign rs2_term_o = rd2_hit ? rd_val : '0;
  assign rs1_busy_o = rd1_hit && busy_q && !wr_hit;
  assign rs2_busy_o = rd2_hit && busy_q && !wr_hit;

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    if (reset_i) begin
      val_d  = RST_VAL;
      busy_d = 1'b0;
    end else begin
      if (wr_hit)
        val_d = wr_val_i;
      else if (IS_SP && sp_adj_go_i)
        val_d = sp_adj_dec_i ? val_q - sp_adj_delta_i : val_q + sp_adj_delta_i;
      // A same-cycle set beats the clear from the producing write.
      busy_d = (busy_q && !wr_hit) || set_hit;
    end
  end

  always_ff @(posedge clk) begin
    val_q  <= val_d;
    busy_q <= busy_d;
  end
endmodule

module regfile #(
  parameter int              XLEN              = 64,
  parameter int              NUM_GP            = 16,
  parameter logic [XLEN-1:0] GP_RESET_VALUE    = '1,
  parameter logic [XLEN-1:0] STACK_RESET_VALUE = '0,
  parameter logic [5:0]      REG_FP            = 6'h16,
  parameter logic [5:0]      REG_SP            = 6'h17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      rs1_sel,
  input  logic [5:0]      rs2_sel,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [5:0]      wr_sel,
  input  logic [XLEN-1:0] wr_val,
  input  logic            sp_adj_en,
  input  logic            sp_adj_dec,
  input  logic [3:0]      sp_adj_amt,
  input  logic            busy_set_en,
  input  logic [5:0]      busy_set_sel,
  output logic            sp_conflict,
  output logic            idx_err
);
  localparam int NREG = NUM_GP + 2;
  localparam int SH   = (XLEN == 64) ? 3 : 2;

  logic [NREG-1:0][XLEN-1:0] rs1_terms, rs2_terms;
  logic [NREG-1:0]           rs1_bhits, rs2_bhits;
  logic [XLEN-1:0]           sp_delta;
  logic                      wr_to_sp, sp_adj_go;
  logic                      conflict_q, conflict_d;
  logic                      idx_err_q, idx_err_d;

  function automatic logic idx_ok(input logic [5:0] idx);
    return ({1'b0, idx} < 7'(NUM_GP)) || (idx == REG_FP) || (idx == REG_SP);
  endfunction

  assign sp_delta  = {{(XLEN-4){1'b0}}, sp_adj_amt} << SH;
  assign wr_to_sp  = wr_en && (wr_sel == REG_SP);
  // A zero-amount adjust is a no-op and must not count as a conflict.
  assign sp_adj_go = !reset && sp_adj_en && (sp_adj_amt != 4'd0) && !wr_to_sp;

  for (genvar s = 0; s < NREG; s++) begin : g_slot
    localparam logic [5:0] IDX = (s == NUM_GP) ? REG_FP : (s == NUM_GP + 1) ? REG_SP : 6'(s);
    localparam logic [XLEN-1:0] RST = (s < NUM_GP) ? GP_RESET_VALUE : STACK_RESET_VALUE;
    regfile_slot #(
      .XLEN(XLEN), .IDX(IDX), .RST_VAL(RST), .IS_SP(s == NUM_GP + 1)
    ) u_slot (
      .clk            (clk),
      .reset_i        (reset),
      .wr_en_i        (wr_en),
      .wr_sel_i       (wr_sel),
      .wr_val_i       (wr_val),
      .sp_adj_go_i    (sp_adj_go),
      .sp_adj_dec_i   (sp_adj_dec),
      .sp_adj_delta_i (sp_delta),
      .busy_set_en_i  (busy_set_en),
      .busy_set_sel_i (busy_set_sel),
      .rs1_sel_i      (rs1_sel),
      .rs2_sel_i      (rs2_sel),
      .rs1_term_o     (rs1_terms[s]),
      .rs2_term_o     (rs2_terms[s]),
      .rs1_busy_o     (rs1_bhits[s]),
      .rs2_busy_o     (rs2_bhits[s])
    );
  end

  // At most one slot matches a selector; an invalid index matches none and reads 0.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int s = 0; s < NREG; s++) begin
      rs1_val = rs1_val | rs1_terms[s];
      rs2_val = rs2_val | rs2_terms[s];
    end
  end

  assign rs1_busy = |rs1_bhits;
  assign rs2_busy = |rs2_bhits;

  always_comb begin
    conflict_d = 1'b0;
    idx_err_d  = 1'b0;
    if (!reset) begin
      conflict_d = wr_to_sp && sp_adj_en && (sp_adj_amt != 4'd0);
      idx_err_d  = idx_err_q || (wr_en && !idx_ok(wr_sel)) ||
                   (busy_set_en && !idx_ok(busy_set_sel));
    end
  end

  always_ff @(posedge clk) begin
    conflict_q <= conflict_d;
    idx_err_q  <= idx_err_d;
  end

  assign sp_conflict = conflict_q;
  assign idx_err     = idx_err_q;
endmodule

// File: tb/tb_regfile.sv
// Randomized scoreboard bench for regfile: expectations are queued at stimulus time and
// compared by an independent monitor on the falling edge.

module tb_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  rs1_sel, rs2_sel, wr_sel, busy_set_sel;
  logic [63:0] rs1_val, rs2_val, wr_val;
  logic        rs1_busy, rs2_busy, wr_en, sp_adj_en, sp_adj_dec, busy_set_en;
  logic [3:0]  sp_adj_amt;
  logic        sp_conflict, idx_err;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .reset(reset),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_val(wr_val),
    .sp_adj_en(sp_adj_en), .sp_adj_dec(sp_adj_dec), .sp_adj_amt(sp_adj_amt),
    .busy_set_en(busy_set_en), .busy_set_sel(busy_set_sel),
    .sp_conflict(sp_conflict), .idx_err(idx_err)
  );

  typedef struct {
    logic [63:0] v1, v2;
    logic        b1, b2, conf, ierr;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_reg  [64];
  bit          m_busy [64];
  bit          m_conf, m_ierr;
  int          checks = 0, errors = 0;

  // Architectural view: g0..g15 at 0..15, fp at 0x16, sp at 0x17, everything else absent.
  function automatic bit valid(input logic [5:0] i);
    return (i < 6'd16) || (i == 6'h16) || (i == 6'h17);
  endfunction

  function automatic logic [63:0] exp_val(input logic [5:0] s);
    if (!valid(s)) return 64'd0;
    if (!reset && wr_en && wr_sel == s) return wr_val;
    return m_reg[s];
  endfunction

  function automatic logic exp_busy(input logic [5:0] s);
    if (!valid(s)) return 1'b0;
    return m_busy[s] && !(!reset && wr_en && wr_sel == s);
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        m_reg[i]  = (i < 16) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
        m_busy[i] = 1'b0;
      end
      m_conf = 1'b0;
      m_ierr = 1'b0;
    end else begin
      bit          wsp;
      logic [63:0] d;
      wsp    = wr_en && (wr_sel == 6'h17);
      d      = 64'(sp_adj_amt) * 64'd8;
      m_conf = wsp && sp_adj_en && (sp_adj_amt != 4'd0);
      if (sp_adj_en && !wsp)
        m_reg[6'h17] = sp_adj_dec ? m_reg[6'h17] - d : m_reg[6'h17] + d;
      if (wr_en && valid(wr_sel)) begin
        m_reg[wr_sel]  = wr_val;
        m_busy[wr_sel] = 1'b0;
      end
      if (busy_set_en && valid(busy_set_sel)) m_busy[busy_set_sel] = 1'b1;
      if ((wr_en && !valid(wr_sel)) || (busy_set_en && !valid(busy_set_sel))) m_ierr = 1'b1;
    end
  endtask

  // Inputs are already applied (posedge+1); queue this cycle's expectation, then advance.
  task automatic step();
    exp_t e;
    e.v1 = exp_val(rs1_sel);  e.v2 = exp_val(rs2_sel);
    e.b1 = exp_busy(rs1_sel); e.b2 = exp_busy(rs2_sel);
    e.conf = m_conf;          e.ierr = m_ierr;
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; sp_adj_en = 0; sp_adj_dec = 0; sp_adj_amt = 0; busy_set_en = 0;
  endtask

  function automatic logic [5:0] rsel();
    int r;
    if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
    r = $urandom_range(0, 17);
    return (r < 16) ? 6'(r) : 6'(r + 6);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (rs1_val !== e.v1 || rs2_val !== e.v2 || rs1_busy !== e.b1 || rs2_busy !== e.b2 ||
          sp_conflict !== e.conf || idx_err !== e.ierr) begin
        errors++;
        $display("FAIL outputs t=%0t sel=%h/%h: val got %h/%h exp %h/%h busy got %b%b exp %b%b conf got %b exp %b ierr got %b exp %b",
                 $time, rs1_sel, rs2_sel, rs1_val, rs2_val, e.v1, e.v2, rs1_busy, rs2_busy,
                 e.b1, e.b2, sp_conflict, e.conf, idx_err, e.ierr);
      end
    end
  end

  initial begin
    reset = 1; idle(); wr_sel = 0; wr_val = 0; busy_set_sel = 0; rs1_sel = 0; rs2_sel = 0;
    @(posedge clk); model_edge(); #1;
    // Still in reset: every action ignored, no bypass.
    wr_en = 1; wr_sel = 3; wr_val = 64'h5; rs1_sel = 3; rs2_sel = 6'h17;
    sp_adj_en = 1; sp_adj_amt = 4; busy_set_en = 1; busy_set_sel = 3;
    step();
    reset = 0; idle();
    for (int i = 0; i < 64; i++) begin
      rs1_sel = 6'(i); rs2_sel = 6'(63 - i); step();
    end
    wr_en = 1; wr_sel = 3; wr_val = 64'h1234; rs1_sel = 3; rs2_sel = 4; step();
    idle(); step();
    sp_adj_en = 1; sp_adj_dec = 1; sp_adj_amt = 2; rs1_sel = 6'h17; step();
    idle(); step();
    sp_adj_en = 1; sp_adj_dec = 0; sp_adj_amt = 2; step();
    idle(); step();
    wr_en = 1; wr_sel = 6'h17; wr_val = 64'h100; sp_adj_en = 1; sp_adj_amt = 3; step();
    idle(); step();
    step();
    wr_en = 1; wr_sel = 6'h17; wr_val = 64'h200; sp_adj_en = 1; sp_adj_amt = 0; step();
    idle(); step();
    busy_set_en = 1; busy_set_sel = 5; rs2_sel = 5; step();
    idle(); step();
    wr_en = 1; wr_sel = 5; wr_val = 64'hABCD; step();
    idle(); step();
    wr_en = 1; wr_sel = 5; wr_val = 64'h77; busy_set_en = 1; busy_set_sel = 5; step();
    idle(); step();
    step();
    wr_en = 1; wr_sel = 6'h20; wr_val = 64'hDEAD; rs1_sel = 0; step();
    idle(); rs1_sel = 6'h20; step();
    step();
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 60) == 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_sel      = ($urandom_range(0, 5) == 0) ? 6'h17 : rsel();
      wr_val      = {$urandom, $urandom};
      sp_adj_en   = ($urandom_range(0, 2) == 0);
      sp_adj_dec  = 1'($urandom_range(0, 1));
      sp_adj_amt  = 4'($urandom_range(0, 15));
      busy_set_en = ($urandom_range(0, 2) == 0);
      busy_set_sel = rsel();
      rs1_sel = ($urandom_range(0, 3) == 0) ? wr_sel : rsel();
      rs2_sel = ($urandom_range(0, 3) == 0) ? busy_set_sel : rsel();
      step();
    end
    reset = 0; idle();
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
